// File: rtl/game_pkg.sv
// game_pkg: state encoding, block-init constant, default parameters and popcount helper
package game_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } state_t;

    localparam logic [15:0] BLOCKS_INIT     = 16'hFFFF;
    localparam int          LIVES_INIT_DEF  = 3;
    localparam int          LOSS_Y_DEF      = 760;
    localparam int          LOST_FRAMES_DEF = 60;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/game_ctl_edge_detect.sv
// edge_detect: registered one-cycle pulse on each 0->1 transition of din
module edge_detect (
    input  logic pclk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic prev;

    always_ff @(posedge pclk) begin
        if (reset) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= din;
            rise <= din & ~prev;
        end
    end
endmodule

// File: rtl/game_ctl.sv
// game_ctl: breakout game flow FSM with lives, saturating score and lost-ball frame delay
module game_ctl
    import game_pkg::*;
#(
    parameter int LIVES_INIT  = LIVES_INIT_DEF,
    parameter int LOSS_Y      = LOSS_Y_DEF,
    parameter int LOST_FRAMES = LOST_FRAMES_DEF
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        mouse_left,
    input  logic [11:0] ball_y,
    input  logic [15:0] blocks_in,
    output logic [2:0]  state,
    output logic        ball_run,
    output logic        ball_rst,
    output logic        blocks_load,
    output logic [15:0] blocks_init,
    output logic [1:0]  lives,
    output logic [7:0]  score
);
    state_t      st, st_d;
    logic        frame_tick, click;
    logic        ball_rst_d, blocks_load_d;
    logic [1:0]  lives_d;
    logic [7:0]  cnt, cnt_d, score_d;
    logic [8:0]  score_sum;
    logic [15:0] blocks_q, blocks_q_d;

    edge_detect u_vsync (.pclk(pclk), .reset(reset), .din(vsync_in),   .rise(frame_tick));
    edge_detect u_click (.pclk(pclk), .reset(reset), .din(mouse_left), .rise(click));

    assign state       = st;
    assign blocks_init = BLOCKS_INIT;
    assign score_sum   = {1'b0, score} + 9'(popcount16(blocks_q & ~blocks_in));

    always_comb begin
        st_d          = st;
        lives_d       = lives;
        cnt_d         = cnt;
        ball_rst_d    = 1'b0;
        blocks_load_d = 1'b0;
        blocks_q_d    = blocks_in;
        score_d       = (st == PLAY) ? (score_sum[8] ? 8'hFF : score_sum[7:0]) : score;
        case (st)
            IDLE: begin
                st_d          = SERVE;
                ball_rst_d    = 1'b1;
                blocks_load_d = 1'b1;
                lives_d       = 2'(LIVES_INIT);
                score_d       = 8'd0;
                blocks_q_d    = BLOCKS_INIT;
            end
            SERVE: st_d = click ? PLAY : SERVE;
            PLAY: begin
                if (blocks_in == 16'd0) begin
                    st_d = WIN;
                end else if (ball_y >= 12'(LOSS_Y)) begin
                    st_d    = LOST;
                    lives_d = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    cnt_d   = 8'd0;
                end
            end
            LOST: begin
                if (cnt == 8'(LOST_FRAMES)) begin
                    st_d       = (lives == 2'd0) ? OVER : SERVE;
                    ball_rst_d = (lives != 2'd0);
                end else if (frame_tick) begin
                    cnt_d = cnt + 8'd1;
                end
            end
            OVER, WIN: st_d = click ? IDLE : st;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            st          <= IDLE;
            ball_run    <= 1'b0;
            ball_rst    <= 1'b0;
            blocks_load <= 1'b0;
            lives       <= 2'(LIVES_INIT);
            score       <= 8'd0;
            cnt         <= 8'd0;
            blocks_q    <= 16'd0;
        end else begin
            st          <= st_d;
            ball_run    <= (st_d == PLAY);
            ball_rst    <= ball_rst_d;
            blocks_load <= blocks_load_d;
            lives       <= lives_d;
            score       <= score_d;
            cnt         <= cnt_d;
            blocks_q    <= blocks_q_d;
        end
    end
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: scoreboard bench; every change of the output tuple is popped and compared
module tb_game_ctl;
    import game_pkg::*;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_in = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] ball_y = 12'd100;
    logic [15:0] blocks_in = 16'hFFFF;
    logic [2:0]  state;
    logic        ball_run, ball_rst, blocks_load;
    logic [15:0] blocks_init;
    logic [1:0]  lives;
    logic [7:0]  score;

    game_ctl dut (
        .pclk(pclk), .reset(reset), .vsync_in(vsync_in), .mouse_left(mouse_left),
        .ball_y(ball_y), .blocks_in(blocks_in), .state(state), .ball_run(ball_run),
        .ball_rst(ball_rst), .blocks_load(blocks_load), .blocks_init(blocks_init),
        .lives(lives), .score(score)
    );

    always #5 pclk = ~pclk;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          passed = 0;
    bit          seen = 1'b0;
    logic [15:0] last, cur, want;
    string       tag;

    function automatic logic [15:0] tup(input state_t s, input logic run, input logic rst,
                                        input logic load, input logic [1:0] lv, input logic [7:0] sc);
        return {s, run, rst, load, lv, sc};
    endfunction

    task automatic expect_out(input string name, input logic [15:0] v);
        exp_q.push_back(v);
        tag_q.push_back(name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic click();
        mouse_left = 1'b1;
        tick(2);
        mouse_left = 1'b0;
        tick(2);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vsync_in = 1'b1;
            tick(2);
            vsync_in = 1'b0;
            tick(2);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL %s: %0d expected output changes never appeared, required 0 pending", name, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // monitor: tuple = {state, ball_run, ball_rst, blocks_load, lives, score}
    always @(negedge pclk) begin
        cur = {state, ball_run, ball_rst, blocks_load, lives, score};
        if (!seen || cur != last) begin
            seen = 1'b1;
            last = cur;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_change: got st=%0d run=%b rst=%b load=%b lives=%0d score=%0d, required no change",
                         cur[15:13], cur[12], cur[11], cur[10], cur[9:8], cur[7:0]);
            end else begin
                want = exp_q.pop_front();
                tag = tag_q.pop_front();
                if (cur == want) passed++;
                else $display("FAIL %s: got st=%0d run=%b rst=%b load=%b lives=%0d score=%0d, required st=%0d run=%b rst=%b load=%b lives=%0d score=%0d",
                              tag, cur[15:13], cur[12], cur[11], cur[10], cur[9:8], cur[7:0],
                              want[15:13], want[12], want[11], want[10], want[9:8], want[7:0]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        expect_out("reset_state", tup(IDLE, 0, 0, 0, 2'd3, 8'd0));
        tick(3);
        expect_out("init_pulses", tup(SERVE, 0, 1, 1, 2'd3, 8'd0));
        expect_out("serve", tup(SERVE, 0, 0, 0, 2'd3, 8'd0));
        reset = 1'b0;
        drain("release");

        expect_out("serve_click", tup(PLAY, 1, 0, 0, 2'd3, 8'd0));
        click();
        drain("serve_click");
        click();
        tick(4);

        expect_out("score_4", tup(PLAY, 1, 0, 0, 2'd3, 8'd4));
        blocks_in = 16'hFFF0;
        tick(1);
        sc = 4;
        for (int i = 0; i < 16; i++) begin
            sc += 15;
            expect_out("score_15", tup(PLAY, 1, 0, 0, 2'd3, 8'(sc)));
            blocks_in = 16'hFFFF;
            tick(1);
            blocks_in = 16'h0001;
            tick(1);
        end
        expect_out("score_254", tup(PLAY, 1, 0, 0, 2'd3, 8'd254));
        blocks_in = 16'hFFFF;
        tick(1);
        blocks_in = 16'hFC00;
        tick(1);
        expect_out("score_sat", tup(PLAY, 1, 0, 0, 2'd3, 8'd255));
        blocks_in = 16'hFFFF;
        tick(1);
        blocks_in = 16'hFFF8;
        tick(1);
        blocks_in = 16'hFFFF;
        tick(1);
        blocks_in = 16'hFFFE;
        tick(1);
        blocks_in = 16'hFFFF;
        drain("score");

        expect_out("loss1", tup(LOST, 0, 0, 0, 2'd2, 8'd255));
        ball_y = 12'd760;
        tick(1);
        ball_y = 12'd100;
        drain("loss1");
        click();
        expect_out("reserve1", tup(SERVE, 0, 1, 0, 2'd2, 8'd255));
        expect_out("serve1", tup(SERVE, 0, 0, 0, 2'd2, 8'd255));
        frames(60);
        drain("reserve1");

        expect_out("play2", tup(PLAY, 1, 0, 0, 2'd2, 8'd255));
        click();
        expect_out("loss2", tup(LOST, 0, 0, 0, 2'd1, 8'd255));
        ball_y = 12'd760;
        tick(1);
        ball_y = 12'd100;
        expect_out("reserve2", tup(SERVE, 0, 1, 0, 2'd1, 8'd255));
        expect_out("serve2", tup(SERVE, 0, 0, 0, 2'd1, 8'd255));
        frames(60);
        drain("loss2");

        expect_out("play3", tup(PLAY, 1, 0, 0, 2'd1, 8'd255));
        click();
        expect_out("loss3", tup(LOST, 0, 0, 0, 2'd0, 8'd255));
        ball_y = 12'd760;
        tick(1);
        ball_y = 12'd100;
        expect_out("over", tup(OVER, 0, 0, 0, 2'd0, 8'd255));
        frames(60);
        drain("over");

        expect_out("over_idle", tup(IDLE, 0, 0, 0, 2'd0, 8'd255));
        expect_out("restart_pulses", tup(SERVE, 0, 1, 1, 2'd3, 8'd0));
        expect_out("restart_serve", tup(SERVE, 0, 0, 0, 2'd3, 8'd0));
        click();
        drain("restart");

        expect_out("play_win", tup(PLAY, 1, 0, 0, 2'd3, 8'd0));
        click();
        expect_out("win_priority", tup(WIN, 0, 0, 0, 2'd3, 8'd16));
        blocks_in = 16'h0000;
        ball_y = 12'd800;
        tick(1);
        blocks_in = 16'hFFFF;
        ball_y = 12'd100;
        drain("win");
        expect_out("win_idle", tup(IDLE, 0, 0, 0, 2'd3, 8'd16));
        expect_out("win_reload", tup(SERVE, 0, 1, 1, 2'd3, 8'd0));
        expect_out("win_serve", tup(SERVE, 0, 0, 0, 2'd3, 8'd0));
        click();
        drain("win_restart");

        expect_out("play_rst", tup(PLAY, 1, 0, 0, 2'd3, 8'd0));
        click();
        expect_out("loss_rst", tup(LOST, 0, 0, 0, 2'd2, 8'd0));
        ball_y = 12'd760;
        tick(1);
        ball_y = 12'd100;
        frames(30);
        drain("loss_rst");
        expect_out("mid_reset", tup(IDLE, 0, 0, 0, 2'd3, 8'd0));
        reset = 1'b1;
        tick(3);
        expect_out("rst_pulses", tup(SERVE, 0, 1, 1, 2'd3, 8'd0));
        expect_out("rst_serve", tup(SERVE, 0, 0, 0, 2'd3, 8'd0));
        reset = 1'b0;
        drain("mid_reset");
        tick(10);

        total++;
        if (blocks_init == 16'hFFFF) passed++;
        else $display("FAIL blocks_init: got %h, required ffff", blocks_init);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/game_ctl.md
GAME_CTL -- requirements
Module: game_ctl

Interface
REQ-001 The module SHALL have parameter LIVES_INIT, 3, number of lives loaded at game start (1..3).
REQ-002 The module SHALL have parameter LOSS_Y, 760, ball y at or beyond which the ball is lost.
REQ-003 The module SHALL have parameter LOST_FRAMES, 60, frames spent in LOST before re-serve (1..255).
REQ-004 The module SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port vsync_in, input, 1, vertical sync from the timing chain; its rising edge is the frame tick.
REQ-007 The module SHALL have port mouse_left, input, 1, left mouse button level, already synchronous to pclk.
REQ-008 The module SHALL have port ball_y, input, 12, current ball y position.
REQ-009 The module SHALL have port blocks_in, input, 16, live block map from the collision detector, 1 = block present.
REQ-010 The module SHALL have port state, output, 3, current game state encoding.
REQ-011 The module SHALL have port ball_run, output, 1, high only in PLAY; enables ball motion.
REQ-012 The module SHALL have port ball_rst, output, 1, one-cycle pulse that recentres the ball on the paddle.
REQ-013 The module SHALL have port blocks_load, output, 1, one-cycle pulse that makes the board load blocks_init.
REQ-014 The module SHALL have port blocks_init, output, 16, block map to load; constant 16'hFFFF.
REQ-015 The module SHALL have port lives, output, 2, remaining lives.
REQ-016 The module SHALL have port score, output, 8, blocks destroyed this game, saturating.

Function
REQ-017 The module SHALL derive frame_tick and click as one-cycle pulses on 0->1 edges of vsync_in and mouse_left, asserted the cycle after the edge is sampled.
REQ-018 The module SHALL implement states IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4, WIN=5.
REQ-019 IDLE SHALL last one cycle: pulse blocks_load and ball_rst, lives<=LIVES_INIT, score<=0, then go to SERVE.
REQ-020 SERVE SHALL hold ball_run low and go to PLAY on click.
REQ-021 PLAY SHALL go to WIN when blocks_in==0, else to LOST when ball_y>=LOSS_Y; WIN has priority when both hold in the same cycle.
REQ-022 Entering LOST SHALL decrement lives and clear an 8-bit frame counter.
REQ-023 LOST SHALL count frame_ticks; when the counter reaches LOST_FRAMES, it SHALL go to OVER if lives==0, else pulse ball_rst and go to SERVE.
REQ-024 OVER and WIN SHALL hold ball_run low and go to IDLE on click.
REQ-025 Clicks in PLAY and LOST SHALL be ignored.
REQ-026 The module SHALL register blocks_in each cycle as blocks_q; in PLAY only, score SHALL increase by popcount(blocks_q & ~blocks_in), saturating at 255.
REQ-027 blocks_q SHALL be loaded with 16'hFFFF on the blocks_load cycle, so that the reload is not counted.
REQ-028 Lives SHALL never underflow; a LOST entry with lives==0 is unreachable by construction.
REQ-029 All outputs SHALL be registered; state changes are visible one cycle after the triggering input is sampled.

Reset
REQ-030 While reset is high, the module SHALL force state=IDLE, ball_run=0, ball_rst=0, blocks_load=0, lives=LIVES_INIT, score=0, counters and edge-detector history to 0.
REQ-031 Reset asserted mid-operation in any state SHALL take effect on the next pclk edge; the first cycle after release SHALL be IDLE.

Structure
REQ-032 Package game_pkg SHALL hold the state encoding, the 16'hFFFF block-init constant and the default parameter values.
REQ-033 The rising-edge detector SHALL be a sub-module edge_detect, instantiated for vsync_in and mouse_left.

Verification
REQ-034 Reset release -> IDLE for 1 cycle with blocks_load=ball_rst=1, then SERVE, lives=3, score=0.
REQ-035 In SERVE, click -> state=PLAY and ball_run=1; a further click in PLAY -> no state change.
REQ-036 In PLAY, blocks_in FFFF->FFF0 in one cycle -> score=4; score at 254 with 3 bits cleared -> score=255.
REQ-037 In PLAY, ball_y=760 -> LOST, lives=2; after 60 vsync edges -> ball_rst pulse and SERVE; third loss -> OVER with lives=0.
REQ-038 In PLAY, blocks_in=0 and ball_y=800 in the same cycle -> WIN, lives unchanged; click -> IDLE, blocks_load pulse.
REQ-039 Reset asserted in LOST after 30 frames -> IDLE next cycle, lives=3, score=0.
